// File: rtl/key_led_pkg.sv
// -----------------------------------------------------------------------------
// key_led_pkg
// Shared definitions for the key-driven LED mode controller:
//   - mode_t     : 2-bit mode encodings (OFF, ON, SLOW blink, FAST blink)
//   - next_mode  : mode sequence OFF -> ON -> SLOW -> FAST -> OFF
//   - cnt_width  : counter width able to hold 0..n-1 (never less than 1 bit)
// -----------------------------------------------------------------------------
package key_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } mode_t;

   function automatic mode_t next_mode(input mode_t cur);
      mode_t nxt;
      case (cur)
         MODE_OFF:  nxt = MODE_ON;
         MODE_ON:   nxt = MODE_SLOW;
         MODE_SLOW: nxt = MODE_FAST;
         default:   nxt = MODE_OFF;
      endcase
      return nxt;
   endfunction

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_led_mode_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, debounce filter and press (falling-edge) detector
// for an active-low push-button.
// Ports:
//   sys_clk     in   system clock
//   sys_rst     in   synchronous active-high reset
//   key_in      in   raw key, active-low, asynchronous
//   key_stable  out  debounced key level (1 = released)
//   press_pulse out  registered one-cycle strobe per accepted press
//   press_next  out  value press_pulse takes on the next edge; lets the
//                    parent update its own state on the same edge as the
//                    strobe
// Parameter: DEBOUNCE_CYC consecutive differing cycles needed to accept a
//            level change.
// -----------------------------------------------------------------------------
module key_debounce
   import key_led_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic key_stable,
   output logic press_pulse,
   output logic press_next
);

   localparam int DW = cnt_width(DEBOUNCE_CYC);

   logic          s1_reg;
   logic          s2_reg;
   logic          stable_reg;
   logic          stable_prev_reg;
   logic          pulse_reg;
   logic [DW-1:0] cnt_reg;

   // Falling edge of the debounced level, one edge after it happened.
   assign press_next = stable_prev_reg & ~stable_reg;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_reg          <= 1'b1;
         s2_reg          <= 1'b1;
         stable_reg      <= 1'b1;
         stable_prev_reg <= 1'b1;
         pulse_reg       <= 1'b0;
         cnt_reg         <= '0;
      end else begin
         s1_reg          <= key_in;
         s2_reg          <= s1_reg;
         stable_prev_reg <= stable_reg;
         pulse_reg       <= press_next;
         if (s2_reg != stable_reg) begin
            if (cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
               stable_reg <= s2_reg;
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + DW'(1);
            end
         end else begin
            // any bounce back discards the partial count
            cnt_reg <= '0;
         end
      end
   end

   assign key_stable  = stable_reg;
   assign press_pulse = pulse_reg;

endmodule

// File: rtl/key_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// key_led_mode_ctrl
// Sequences the board LED from one push-button: each accepted press steps the
// mode OFF -> ON -> SLOW blink -> FAST blink -> OFF.
// Ports:
//   sys_clk     in   system clock (sole domain)
//   sys_rst     in   synchronous active-high reset
//   key_in      in   raw key, active-low, asynchronous
//   led_out     out  LED drive, 1 = lit
//   mode_out    out  current mode (0 OFF, 1 ON, 2 SLOW, 3 FAST)
//   press_pulse out  one-cycle strobe per accepted press
// Optional feature: define KEY_LED_LONG_PRESS_EN to build a hold counter that
// forces the mode to OFF once the key has been held for LONG_CYC cycles.
// -----------------------------------------------------------------------------
module key_led_mode_ctrl
   import key_led_pkg::*;
#(
   parameter int DEBOUNCE_CYC  = 1000000,
   parameter int SLOW_HALF_CYC = 12500000,
   parameter int FAST_HALF_CYC = 2500000,
   parameter int LONG_CYC      = 50000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_in,
   output logic       led_out,
   output logic [1:0] mode_out,
   output logic       press_pulse
);

   localparam int BLINK_MAX = (SLOW_HALF_CYC > FAST_HALF_CYC) ? SLOW_HALF_CYC : FAST_HALF_CYC;
   localparam int BW        = cnt_width(BLINK_MAX);

   logic key_stable;
   logic press_next;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .key_stable  (key_stable),
      .press_pulse (press_pulse),
      .press_next  (press_next)
   );

   mode_t         mode_reg,  mode_next;
   logic          led_reg,   led_next;
   logic [BW-1:0] blink_reg, blink_next;
   logic          hold_fire;

`ifdef KEY_LED_LONG_PRESS_EN
   localparam int HW = cnt_width(LONG_CYC);

   logic [HW-1:0] hold_reg;

   // Fires on the edge the counter steps onto LONG_CYC-1; it then sits there
   // until release, so it can fire only once per hold.
   assign hold_fire = ~key_stable
                      && (hold_reg != HW'(LONG_CYC - 1))
                      && (hold_reg == HW'(LONG_CYC - 2));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         hold_reg <= '0;
      end else if (key_stable) begin
         hold_reg <= '0;
      end else if (hold_reg != HW'(LONG_CYC - 1)) begin
         hold_reg <= hold_reg + HW'(1);
      end
   end
`else
   logic unused_key_stable;

   assign hold_fire         = 1'b0;
   assign unused_key_stable = key_stable;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         mode_reg  <= MODE_OFF;
         led_reg   <= 1'b0;
         blink_reg <= '0;
      end else begin
         mode_reg  <= mode_next;
         led_reg   <= led_next;
         blink_reg <= blink_next;
      end
   end

   always_comb begin
      mode_next  = mode_reg;
      led_next   = led_reg;
      blink_next = '0;

      if (press_next) begin
         // a press beats a blink wrap on the same edge: entry values only
         mode_next = next_mode(mode_reg);
         led_next  = (mode_next != MODE_OFF);
      end else begin
         case (mode_reg)
            MODE_OFF: led_next = 1'b0;
            MODE_ON:  led_next = 1'b1;
            MODE_SLOW: begin
               if (blink_reg == BW'(SLOW_HALF_CYC - 1)) begin
                  led_next = ~led_reg;
               end else begin
                  blink_next = blink_reg + BW'(1);
               end
            end
            default: begin
               if (blink_reg == BW'(FAST_HALF_CYC - 1)) begin
                  led_next = ~led_reg;
               end else begin
                  blink_next = blink_reg + BW'(1);
               end
            end
         endcase
      end

      if (hold_fire) begin
         mode_next  = MODE_OFF;
         led_next   = 1'b0;
         blink_next = '0;
      end
   end

   assign led_out  = led_reg;
   assign mode_out = mode_reg;

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_led_mode_ctrl
// Self-checking bench for key_led_mode_ctrl with short timing parameters.
// A behavioural model (key sample history, run-length debounce, mode index
// arithmetic, LED phase computed from time since mode entry) predicts every
// output after every edge. Directed steps are followed by random key traffic.
// -----------------------------------------------------------------------------
module tb_key_led_mode_ctrl;

   localparam int DEB  = 4;
   localparam int SLOW = 8;
   localparam int FAST = 2;
   localparam int LONG = 20;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       key_in  = 1'b0;
   logic       led_out;
   logic [1:0] mode_out;
   logic       press_pulse;

   int checks = 0;
   int errors = 0;

   key_led_mode_ctrl #(
      .DEBOUNCE_CYC  (DEB),
      .SLOW_HALF_CYC (SLOW),
      .FAST_HALF_CYC (FAST),
      .LONG_CYC      (LONG)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .led_out     (led_out),
      .mode_out    (mode_out),
      .press_pulse (press_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   // ---------------- reference model ----------------
   int t        = 0;  // edge counter
   bit hist [2] = '{1'b1, 1'b1};  // key samples of the last two edges, [1] oldest
   bit m_stable = 1'b1;
   int m_run    = 0;  // consecutive edges where the synced key differs
   bit m_fell   = 1'b0;
   int m_mode   = 0;
   int m_entry  = 0;
   int m_hold   = 0;
   bit exp_pulse;
   bit exp_led;

   task automatic model_edge(input bit k, input bit r);
      bit old_stable;
      bit synced;
      if (r) begin
         hist     = '{1'b1, 1'b1};
         m_stable = 1'b1;
         m_run    = 0;
         m_fell   = 1'b0;
         m_mode   = 0;
         m_entry  = t;
         m_hold   = 0;
         exp_pulse = 1'b0;
      end else begin
         old_stable = m_stable;
         synced     = hist[1];
         exp_pulse  = m_fell;
         m_fell     = 1'b0;
         if (synced != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
               m_stable = synced;
               m_run    = 0;
               m_fell   = (synced == 1'b0);
            end
         end else begin
            m_run = 0;
         end
         hist[1] = hist[0];
         hist[0] = k;
         if (exp_pulse) begin
            m_mode  = (m_mode + 1) % 4;
            m_entry = t;
         end
`ifdef KEY_LED_LONG_PRESS_EN
         if (old_stable == 1'b0) begin
            if (m_hold < LONG - 1) begin
               m_hold++;
               if (m_hold == LONG - 1) m_mode = 0;
            end
         end else begin
            m_hold = 0;
         end
`else
         if (old_stable == 1'b0) m_hold++;
`endif
      end
      case (m_mode)
         0:       exp_led = 1'b0;
         1:       exp_led = 1'b1;
         2:       exp_led = (((t - m_entry) / SLOW) % 2) == 0;
         default: exp_led = (((t - m_entry) / FAST) % 2) == 0;
      endcase
      t++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d t=%0d", tag, obs, exp, t);
      end
   endtask

   // drive one cycle, advance the model, compare all outputs #1 after the edge
   task automatic step(input bit k, input bit r);
      key_in  = k;
      sys_rst = r;
      @(posedge sys_clk);
      model_edge(k, r);
      #1;
      chk("press_pulse", {31'd0, press_pulse}, {31'd0, exp_pulse});
      chk("mode_out",    {30'd0, mode_out},    m_mode);
      chk("led_out",     {31'd0, led_out},     {31'd0, exp_led});
      if (exp_pulse)
         $display("press t=%0d mode=%0d led=%0d", t, mode_out, led_out);
   endtask

   task automatic press(input int low, input int high);
      repeat (low)  step(1'b0, 1'b0);
      repeat (high) step(1'b1, 1'b0);
   endtask

   initial begin
      int first;
      int npulse;
      bit k;
      int runlen;

      // reset held with key pressed, then released with key up
      repeat (3) step(1'b0, 1'b1);
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         if (press_pulse === 1'b1) npulse++;
      end
      chk("no_pulse_after_reset", npulse, 0);

      // clean press: pulse after edge 6 counting the first low sample as edge 0
      first = -1; npulse = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         if (press_pulse === 1'b1) begin
            npulse++;
            if (first < 0) first = i;
         end
      end
      chk("clean_latency", first, 6);
      chk("clean_count", npulse, 1);
      chk("clean_mode", {30'd0, mode_out}, 1);
      repeat (8) step(1'b1, 1'b0);

      // bounce: low 3, high 1, low -> single pulse after edge 10
      first = -1; npulse = 0;
      for (int i = 0; i < 16; i++) begin
         step((i == 3) ? 1'b1 : 1'b0, 1'b0);
         if (press_pulse === 1'b1) begin
            npulse++;
            if (first < 0) first = i;
         end
      end
      chk("bounce_latency", first, 10);
      chk("bounce_count", npulse, 1);
      repeat (8) step(1'b1, 1'b0);

      // mode cycling from OFF with blink observation
      step(1'b1, 1'b1);
      press(8, 8);
      chk("cycle_mode1", {30'd0, mode_out}, 1);
      press(8, 30);
      chk("cycle_mode2", {30'd0, mode_out}, 2);
      press(8, 12);
      chk("cycle_mode3", {30'd0, mode_out}, 3);
      press(8, 8);
      chk("cycle_mode0", {30'd0, mode_out}, 0);
      chk("cycle_led0", {31'd0, led_out}, 0);

      // mid-blink reset, then restart at ON
      press(8, 8);
      press(8, 3);
      step(1'b1, 1'b1);
      chk("midrst_mode", {30'd0, mode_out}, 0);
      chk("midrst_led", {31'd0, led_out}, 0);
      press(8, 8);
      chk("midrst_restart", {30'd0, mode_out}, 1);

      // long hold from OFF
      step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);
      first = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0);
         if (i > 6 && first < 0 && mode_out === 2'd0) first = i;
      end
`ifdef KEY_LED_LONG_PRESS_EN
      chk("long_fire_edge", first, 24);
      chk("long_mode", {30'd0, mode_out}, 0);
      chk("long_led", {31'd0, led_out}, 0);
      press(0, 8);
      press(8, 8);
      chk("long_repress", {30'd0, mode_out}, 1);
`else
      chk("long_fire_edge", first, -1);
      chk("long_mode", {30'd0, mode_out}, 1);
      press(0, 8);
      press(8, 8);
      chk("long_repress", {30'd0, mode_out}, 2);
`endif

      // random key traffic with occasional reset
      k = 1'b1;
      for (int n = 0; n < 120; n++) begin
         runlen = $urandom_range(1, (n % 3 == 0) ? 30 : 8);
         k = ~k;
         for (int j = 0; j < runlen; j++)
            step(k, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_led_mode_ctrl.md
Name: key_led_mode_ctrl

Overview:
- Controller that sequences the board LED from a single push-button.
- Synchronises and debounces the raw key, then detects press events.
- Steps a 4-state mode FSM (OFF, ON, SLOW blink, FAST blink) on each press and drives the LED register accordingly.
- Sits between the board key pin and the LED pin, replacing the direct key-to-LED register path.

Parameters:
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- SLOW_HALF_CYC, 12500000: LED half-period in SLOW mode (250 ms).
- FAST_HALF_CYC, 2500000: LED half-period in FAST mode (50 ms).
- LONG_CYC, 50000000: hold time for a long press (1 s); used only with LONG_PRESS_EN.

Ports:
- sys_clk  in  1  system clock; sole clock domain.
- sys_rst  in  1  synchronous, active-high reset.
- key_in  in  1  raw key, active-low (0 = pressed), asynchronous to sys_clk.
- led_out  out  1  LED drive, 1 = lit.
- mode_out  out  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST.
- press_pulse  out  1  one-cycle strobe per accepted press.

Behaviour:
- All state is updated only on the sys_clk rising edge; sys_rst is sampled synchronously.
- Reset values:
  - synchroniser flops = 1; debounced level key_stable = 1 (released).
  - debounce counter = 0; blink counter = 0.
  - mode_out = 0 (OFF); led_out = 0; press_pulse = 0.
- Reset asserted mid-operation (mid-debounce, mid-blink, mid-hold) returns every register to its reset value on that edge.
- Synchroniser: two-flop chain key_in -> s1 -> s2.
- Debounce:
  - While s2 == key_stable, the counter clears to 0.
  - While s2 != key_stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 with s2 still differing: key_stable <= s2 and the counter clears.
  - Any bounce back clears the counter; partial counts are never retained.
- Press detection: a key_stable 1->0 transition registers press_pulse = 1 for exactly one cycle. Release (0->1) produces no pulse.
- Latency: key_in held low from edge 0 gives press_pulse high after edge DEBOUNCE_CYC+2, i.e. visible in cycle DEBOUNCE_CYC+3.
- Mode FSM:
  - Advances OFF->ON->SLOW->FAST->OFF.
  - mode_out and led_out update on the same edge that asserts press_pulse.
- LED output per mode:
  - OFF: led_out = 0.
  - ON: led_out = 1.
  - SLOW and FAST: on mode entry, the blink counter clears and led_out = 1. The counter counts 0..HALF-1; at HALF-1 led_out toggles and the counter wraps to 0.
  - Toggle period is exactly HALF cycles; the blink counter width is sized for the larger of SLOW_HALF_CYC and FAST_HALF_CYC.
- Simultaneous events: if a press arrives on the same edge as a blink wrap, the mode change wins. The new mode's entry values apply and no toggle occurs.
- Counters never overflow; each is compared against its terminal value and saturates or wraps only as stated above.

Optional Feature:
- Macro: KEY_LED_LONG_PRESS_EN.
- Defined:
  - A hold counter runs while key_stable == 0 and clears when key_stable == 1.
  - When the hold counter reaches LONG_CYC-1, mode is forced to OFF and led_out = 0 on that edge.
  - Fires at most once per hold; the counter saturates until release.
  - The press_pulse from the start of that hold has already advanced the mode; the forced OFF overrides it.
- Undefined: no hold counter is built; holding the key has no effect beyond the initial press.

Decomposition:
- Package key_led_pkg holds:
  - the 2-bit mode encodings MODE_OFF/MODE_ON/MODE_SLOW/MODE_FAST;
  - a function returning the next mode;
  - a clog2-based width helper for the counters.
- Sub-module key_debounce (synchroniser + debounce + press edge detect): inputs sys_clk, sys_rst, key_in; outputs key_stable, press_pulse; parameter DEBOUNCE_CYC.
- The top level holds the mode FSM, blink counter and optional hold counter.

Test Plan (bench uses DEBOUNCE_CYC=4, SLOW_HALF_CYC=8, FAST_HALF_CYC=2, LONG_CYC=20):
- Reset: assert sys_rst 3 cycles with key_in=0 -> led_out=0, mode_out=0, press_pulse=0 throughout. After release with key_in=1, no pulse occurs.
- Clean press: key_in 1->0 held -> press_pulse high exactly in cycle 7 after the drop, for 1 cycle. mode_out=1 and led_out=1 in that same cycle.
- Bounce: key_in low 3 cycles, high 1 cycle, low again -> no pulse until 4 consecutive synchronized-low cycles. Exactly one pulse.
- Mode cycling: 4 clean presses -> mode_out 1,2,3,0. In mode 2, led_out toggles every 8 cycles starting at 1. In mode 3, every 2 cycles. After the 4th press, led_out=0.
- Mid-operation reset: in SLOW mode mid-count, pulse sys_rst 1 cycle -> next cycle mode_out=0, led_out=0. A following press restarts at ON.
- LONG_PRESS (macro defined): from OFF, hold the key 30 cycles -> mode_out=1 at the press, then 0 with led_out=0 at hold count 19. After release and re-press, mode_out=1. With the macro undefined, the same stimulus leaves mode_out=1.
